// File: rtl/debouncer_multi.sv
// Multi-channel debouncer. Each channel has an input synchroniser, a stability-window
// counter and registered rise/fall one-shots. any_change is the OR of the pulses.
module debouncer_multi #(
    parameter int                N_CH        = 4,
    parameter int                N_MAX       = 5000,
    parameter int                SYNC_STAGES = 2,
    parameter logic [N_CH-1:0]   INVERT_MASK = '0
) (
    input  logic            clk,
    input  logic            rst_a_p,
    input  logic [N_CH-1:0] debouncer_in,
    output logic [N_CH-1:0] debouncer_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            any_change
);

    localparam int CW = ($clog2(N_MAX) < 1) ? 1 : $clog2(N_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_MAX - 1);

    logic [N_CH-1:0] rise_d;
    logic [N_CH-1:0] fall_d;
    logic            any_change_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   out_q, out_d;
        logic                   rise_q, fall_q;
        logic                   s;

        // Reset preloads the pin's inactive level so s starts equal to the output.
        assign s = sync_q[SYNC_STAGES-1] ^ INVERT_MASK[gi];

        always_comb begin
            out_d      = out_q;
            cnt_d      = cnt_q;
            rise_d[gi] = 1'b0;
            fall_d[gi] = 1'b0;
            if (s == out_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                out_d      = s;
                cnt_d      = '0;
                rise_d[gi] = s;
                fall_d[gi] = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst_a_p) begin
                sync_q <= {SYNC_STAGES{INVERT_MASK[gi]}};
                cnt_q  <= '0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], debouncer_in[gi]};
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                rise_q <= rise_d[gi];
                fall_q <= fall_d[gi];
            end
        end

        assign debouncer_out[gi] = out_q;
        assign rise_pulse[gi]    = rise_q;
        assign fall_pulse[gi]    = fall_q;
    end

    // Registered from the same next-state terms as the pulses, so it lines up with them.
    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= |{rise_d, fall_d};
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: directed scenarios with literal expectations plus random
// stimulus, all checked every cycle against a window-based behavioural model.
module tb_debouncer_multi;

    localparam int         N_CH  = 4;
    localparam int         N_MAX = 4;
    localparam int         SYNC  = 2;
    localparam logic [3:0] MASK  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_a_p;
    logic [3:0] debouncer_in;
    logic [3:0] debouncer_out, rise_pulse, fall_pulse;
    logic       any_change;

    int n_vec = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    debouncer_multi #(
        .N_CH(N_CH), .N_MAX(N_MAX), .SYNC_STAGES(SYNC), .INVERT_MASK(MASK)
    ) dut (
        .clk(clk), .rst_a_p(rst_a_p), .debouncer_in(debouncer_in),
        .debouncer_out(debouncer_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .any_change(any_change)
    );

    always #5 clk = ~clk;

    // Behavioural model: the synchronised value of a pin is its level SYNC edges ago
    // (mask level right after reset); the level flips once the last N_MAX synchronised
    // samples all disagree with it.
    logic [3:0] m_out = '0, m_rise = '0, m_fall = '0;
    logic       m_any = 1'b0;
    logic [3:0] pin_dly [$];
    logic [3:0] s_hist  [$];

    always @(posedge clk) begin
        logic [3:0] s;
        bit         all_diff;
        if (rst_a_p) begin
            m_out = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
            pin_dly.delete();
            repeat (SYNC) pin_dly.push_back(MASK);
            s_hist.delete();
        end else if (pin_dly.size() == SYNC) begin
            s = pin_dly.pop_front() ^ MASK;
            pin_dly.push_back(debouncer_in);
            s_hist.push_back(s);
            if (s_hist.size() > N_MAX) void'(s_hist.pop_front());
            m_rise = '0; m_fall = '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                all_diff = (s_hist.size() == N_MAX);
                for (int j = 0; j < s_hist.size(); j++)
                    if (s_hist[j][ch] == m_out[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_out[ch]  = s[ch];
                    m_rise[ch] = s[ch];
                    m_fall[ch] = ~s[ch];
                end
            end
            m_any = |{m_rise, m_fall};
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_vec++;
            if (debouncer_out !== m_out || rise_pulse !== m_rise ||
                fall_pulse !== m_fall || any_change !== m_any) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t got out=%b rise=%b fall=%b any=%b exp out=%b rise=%b fall=%b any=%b",
                         $time, debouncer_out, rise_pulse, fall_pulse, any_change,
                         m_out, m_rise, m_fall, m_any);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got {out,rise,fall,any}=%b exp %b", name, $time, got, exp);
        end else begin
            $display("ok   %s t=%0t {out,rise,fall,any}=%b", name, $time, got);
        end
    endtask

    function automatic logic [12:0] outs();
        return {debouncer_out, rise_pulse, fall_pulse, any_change};
    endfunction

    initial begin
        repeat (SYNC) pin_dly.push_back(MASK);
        rst_a_p      = 1'b1;
        debouncer_in = 4'b1000;
        tick(3);
        check("reset_state", outs(), 13'b0000_0000_0000_0);
        rst_a_p  = 1'b0;
        check_en = 1'b1;
        tick(10);
        check("inv_idle", outs(), 13'b0000_0000_0000_0);

        // Clean press on channel 0
        debouncer_in[0] = 1'b1;
        tick(5);  check("press_before", outs(), 13'b0000_0000_0000_0);
        tick(1);  check("press_rise",   outs(), 13'b0001_0001_0000_1);
        tick(1);  check("press_after",  outs(), 13'b0001_0000_0000_0);
        tick(14);

        // Release on channel 0
        debouncer_in[0] = 1'b0;
        tick(5);  check("rel_before", outs(), 13'b0001_0000_0000_0);
        tick(1);  check("rel_fall",   outs(), 13'b0000_0000_0001_1);
        tick(1);  check("rel_after",  outs(), 13'b0000_0000_0000_0);

        // Bounce on channel 1, then hold high
        for (int r = 0; r < 2; r++) begin
            debouncer_in[1] = 1'b1; tick(2);
            debouncer_in[1] = 1'b0; tick(2);
        end
        check("bounce_quiet", outs(), 13'b0000_0000_0000_0);
        debouncer_in[1] = 1'b1;
        tick(5);  check("bounce_before", outs(), 13'b0000_0000_0000_0);
        tick(1);  check("bounce_rise",   outs(), 13'b0010_0010_0000_1);
        tick(1);

        // Active-low channel 3 pressed
        debouncer_in[3] = 1'b0;
        tick(5);  check("inv_before", outs(), 13'b0010_0000_0000_0);
        tick(1);  check("inv_rise",   outs(), 13'b1010_1000_0000_1);
        tick(1);

        // Simultaneous press on channels 2..0
        debouncer_in = 4'b0000;
        tick(8);  check("simul_idle", outs(), 13'b1000_0000_0000_0);
        debouncer_in = 4'b0111;
        tick(5);  check("simul_before", outs(), 13'b1000_0000_0000_0);
        tick(1);  check("simul_rise",   outs(), 13'b1111_0111_0000_1);
        tick(1);  check("simul_after",  outs(), 13'b1111_0000_0000_0);

        // Reset mid-count; channels 0 and 3 held active through reset
        debouncer_in = 4'b0000;
        tick(8);
        debouncer_in = 4'b0001;
        tick(3);
        rst_a_p = 1'b1;
        tick(1);  check("midrst_clear", outs(), 13'b0000_0000_0000_0);
        rst_a_p = 1'b0;
        tick(5);  check("midrst_before", outs(), 13'b0000_0000_0000_0);
        tick(1);  check("midrst_rise",   outs(), 13'b1001_1001_0000_1);
        tick(1);

        // Random phase: alternating glitchy and calm periods, rare resets
        for (int c = 0; c < 3000; c++) begin
            int rate;
            rate = ((c / 200) % 2 == 0) ? 3 : 25;
            for (int ch = 0; ch < N_CH; ch++)
                if ($urandom_range(rate - 1, 0) == 0) debouncer_in[ch] = ~debouncer_in[ch];
            rst_a_p = ($urandom_range(399, 0) == 0);
            tick(1);
        end
        rst_a_p = 1'b0;
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
